fifo_drain_ctrl: RTL and testbench

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_drain_ctrl.sv | 85 ++++++++
 tb/tb_fifo_drain_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - drains an upstream FIFO into a 2-entry ready/valid output buffer
// Reads are issued only when the buffer plus the in-flight word leave room, so the buffer never overflows.
module fifo_drain_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [FIFO_WIDTH-1:0] buf_mem [2];
  logic                  pop;
  logic [1:0]            committed;

  // Outputs are forced quiet while rst is high so no read or pop can slip through a reset cycle.
  always_comb begin
    m_valid    = !rst && (occ != 2'd0);
    pop        = m_valid && m_ready;
    committed  = occ + {1'b0, inflight} - {1'b0, pop};
    fifo_rd_en = !rst && (state == RUN) && enable && !fifo_empty && (committed < 2'd2);
    busy       = !rst && (state != IDLE);
    m_data     = buf_mem[rd_ptr];
  end

  // A returning enable takes priority over finishing a drain.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) state_nxt = ((occ != 2'd0) || inflight) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable)                            state_nxt = RUN;
        else if ((occ == 2'd0) && !inflight)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      rd_count   <= '0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (inflight) begin
        buf_mem[wr_ptr] <= fifo_data_out;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        rd_count <= rd_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - randomized and directed bench for fifo_drain_ctrl
// Reference model holds the upstream FIFO, output buffer and in-flight word as queues.
module tb_fifo_drain_ctrl;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] rd_count;
  logic          busy;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .rd_count(rd_count), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0]  upq[$];
  logic [W-1:0]  outq[$];
  logic [W-1:0]  flight[$];
  logic [W-1:0]  popped[$];
  int            pop_cyc[$];
  int            mode;
  logic [CW-1:0] cnt;
  int            delivered;
  int            reads_issued;
  int            cyc;
  logic [W-1:0]  next_word;

  logic          o_rd, o_valid, o_busy;
  logic [W-1:0]  o_data;
  logic [CW-1:0] o_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word();
    upq.push_back(next_word);
    next_word++;
  endtask

  // One clock: drive at negedge, compare against the model, advance the model at posedge.
  task automatic cycle(input logic en, input logic rdy, input logic r);
    int occ0, inf0;
    logic val_e, pop_e, rd_e;
    logic [W-1:0] w;
    rst = r; enable = en; m_ready = rdy; fifo_empty = (upq.size() == 0);
    #1;
    o_rd = fifo_rd_en; o_valid = m_valid; o_busy = busy; o_data = m_data; o_cnt = rd_count;
    occ0  = outq.size();
    inf0  = flight.size();
    val_e = !r && (occ0 > 0);
    pop_e = val_e && rdy;
    rd_e  = !r && (mode == 1) && en && (upq.size() > 0) && (occ0 + inf0 - int'(pop_e) < 2);
    check("fifo_rd_en", {31'd0, o_rd}, {31'd0, rd_e});
    check("underflow", {31'd0, o_rd & fifo_empty}, 32'd0);
    check("m_valid", {31'd0, o_valid}, {31'd0, val_e});
    check("busy", {31'd0, o_busy}, {31'd0, !r && (mode != 0)});
    check("rd_count", {16'd0, o_cnt}, {16'd0, cnt});
    if (val_e) check("m_data", {16'd0, o_data}, {16'd0, outq[0]});
    if (o_valid && rdy) begin
      popped.push_back(o_data);
      pop_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (r) begin
      outq.delete(); flight.delete(); mode = 0; cnt = '0;
    end else begin
      if (pop_e) begin
        void'(outq.pop_front());
        cnt++;
        delivered++;
      end
      if (inf0 > 0) outq.push_back(flight.pop_front());
      case (mode)
        0: if (en) mode = 1;
        1: if (!en) mode = (occ0 > 0 || inf0 > 0) ? 2 : 0;
        default: if (en) mode = 1; else if (occ0 == 0 && inf0 == 0) mode = 0;
      endcase
    end
    #1;
    if (o_rd && upq.size() > 0) begin
      w = upq.pop_front();
      fifo_data_out = w;
      if (!r) flight.push_back(w);
      reads_issued++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int r0, d0, held, d_rst, left0, pushed;
    logic [W-1:0] first;
    logic en_r;
    rst = 1'b1; enable = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data_out = '0;
    mode = 0; cnt = '0; delivered = 0; reads_issued = 0; cyc = 0; next_word = 16'h0001;
    repeat (8) push_word();
    fifo_empty = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles with enable high and FIFO non-empty
    cycle(1, 1, 1);
    cycle(1, 1, 1);

    // Streaming 0x0001..0x0008
    popped.delete(); pop_cyc.delete();
    repeat (14) cycle(1, 1, 0);
    check("stream_count", popped.size(), 8);
    for (int i = 0; i < popped.size() && i < 8; i++)
      check("stream_data", {16'd0, popped[i]}, i + 1);
    if (pop_cyc.size() == 8) check("stream_back_to_back", pop_cyc[7] - pop_cyc[0], 7);
    check("stream_rd_count", {16'd0, rd_count}, 8);
    repeat (3) cycle(0, 1, 0);
    check("stream_idle", {31'd0, o_busy}, 0);

    // Backpressure: 4 words, m_ready low
    r0 = reads_issued; first = next_word; held = 0;
    repeat (4) push_word();
    repeat (14) begin
      cycle(1, 0, 0);
      if (o_valid && o_data === first) held++;
    end
    check("bp_reads", reads_issued - r0, 2);
    check("bp_hold", {31'd0, held >= 10}, 1);
    popped.delete();
    repeat (8) cycle(1, 1, 0);
    check("bp_delivered", popped.size(), 4);
    for (int i = 0; i < popped.size() && i < 4; i++)
      check("bp_order", {16'd0, popped[i]}, {16'd0, first} + i);

    // Enable drop right after a read is issued
    repeat (3) cycle(0, 1, 0);
    r0 = reads_issued; d0 = delivered;
    repeat (4) push_word();
    cycle(1, 1, 0);
    cycle(1, 1, 0);
    check("drop_rd_issued", {31'd0, o_rd}, 1);
    cycle(0, 1, 0);
    check("drop_rd_stopped", {31'd0, o_rd}, 0);
    cycle(0, 1, 0);
    check("drain_busy", {31'd0, o_busy}, 1);
    check("drain_valid", {31'd0, o_valid}, 1);
    repeat (3) cycle(0, 1, 0);
    check("drain_idle", {31'd0, o_busy}, 0);
    check("drain_reads", reads_issued - r0, 1);
    check("drain_delivered", delivered - d0, 1);

    // Reset with a full buffer
    repeat (2) push_word();
    repeat (6) cycle(1, 0, 0);
    check("pre_rst_valid", {31'd0, o_valid}, 1);
    cycle(1, 1, 1);
    cycle(0, 0, 0);
    check("rst_mid_valid", {31'd0, o_valid}, 0);
    check("rst_mid_count", {16'd0, o_cnt}, 0);
    check("rst_mid_busy", {31'd0, o_busy}, 0);

    // Random traffic
    d_rst = delivered;
    left0 = upq.size() + outq.size() + flight.size();
    pushed = 0; en_r = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (upq.size() < 24 && $urandom_range(0, 99) < 45) begin
        push_word();
        pushed++;
      end
      if ($urandom_range(0, 19) == 0) en_r = ~en_r;
      cycle(en_r, $urandom_range(0, 3) != 0, 0);
    end
    check("rand_conservation", (delivered - d_rst) + upq.size() + outq.size() + flight.size(),
          pushed + left0);
    check("rand_rd_count", {16'd0, rd_count}, (delivered - d_rst) & 32'hFFFF);
    check("rand_traffic", {31'd0, (delivered - d_rst) > 1000}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
